// File: rtl/codificador_pt2262.sv
// PT2262-compatible remote-control encoder: 8 address trits plus 4 data bits,
// serialised as pulse-width symbols followed by a sync gap, repeated while te is high.
module codificador_pt2262 #(
    parameter int unsigned ALPHA_CYC = 250,
    parameter int unsigned MIN_WORDS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] A_01,
    input  logic [7:0] A_F,
    input  logic [3:0] D,
    input  logic       te,
    output logic       cod_o,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, BIT, SYNC} state_t;

    localparam logic [15:0] PRE_MAX = 16'(ALPHA_CYC - 1);
    localparam logic [3:0]  MIN_W   = 4'(MIN_WORDS);

    state_t      state_q, state_d;
    logic [15:0] pre_q, pre_d;
    logic [6:0]  acnt_q, acnt_d;
    logic [3:0]  bidx_q, bidx_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [23:0] sr_q, sr_d;
    logic        cod_q, cod_d;
    logic        busy_q, busy_d;

    logic        tick;
    logic [3:0]  wcnt_inc;
    logic        half_long;
    logic [3:0]  hi_len;

    // Each trit is stored as {first half long, second half long}: 0=00, 1=11, F=01.
    function automatic logic [23:0] load_word(input logic [7:0] a01, input logic [7:0] af,
                                              input logic [3:0] d);
        logic [23:0] w;
        w = '0;
        for (int unsigned k = 0; k < 4; k++)
            w[2*k +: 2] = {d[k], d[k]};
        for (int unsigned i = 0; i < 8; i++)
            w[2*(i+4) +: 2] = af[i] ? 2'b01 : {a01[i], a01[i]};
        return w;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pre_q   <= '0;
            acnt_q  <= '0;
            bidx_q  <= '0;
            wcnt_q  <= '0;
            sr_q    <= '0;
            cod_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            acnt_q  <= acnt_d;
            bidx_q  <= bidx_d;
            wcnt_q  <= wcnt_d;
            sr_q    <= sr_d;
            cod_q   <= cod_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        acnt_d   = acnt_q;
        bidx_d   = bidx_q;
        wcnt_d   = wcnt_q;
        sr_d     = sr_q;
        tick     = (pre_q == PRE_MAX);
        wcnt_inc = (wcnt_q == 4'd15) ? 4'd15 : wcnt_q + 4'd1;

        case (state_q)
            IDLE: begin
                pre_d  = '0;
                acnt_d = '0;
                bidx_d = '0;
                if (te) begin
                    sr_d    = load_word(A_01, A_F, D);
                    wcnt_d  = '0;
                    state_d = BIT;
                end
            end
            BIT: begin
                if (!tick) begin
                    pre_d = pre_q + 16'd1;
                end else begin
                    pre_d = '0;
                    if (acnt_q == 7'd31) begin
                        acnt_d = '0;
                        sr_d   = {sr_q[21:0], 2'b00};
                        if (bidx_q == 4'd11) begin
                            bidx_d  = '0;
                            state_d = SYNC;
                        end else begin
                            bidx_d = bidx_q + 4'd1;
                        end
                    end else begin
                        acnt_d = acnt_q + 7'd1;
                    end
                end
            end
            SYNC: begin
                if (!tick) begin
                    pre_d = pre_q + 16'd1;
                end else begin
                    pre_d = '0;
                    if (acnt_q == 7'd127) begin
                        acnt_d = '0;
                        wcnt_d = wcnt_inc;
                        if (te || (wcnt_inc < MIN_W)) begin
                            sr_d    = load_word(A_01, A_F, D);
                            state_d = BIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        acnt_d = acnt_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next position so the registered level lines up with it.
    always_comb begin
        half_long = acnt_d[4] ? sr_d[22] : sr_d[23];
        hi_len    = half_long ? 4'd12 : 4'd4;
        cod_d     = 1'b0;
        case (state_d)
            BIT:     cod_d = (acnt_d[3:0] < hi_len);
            SYNC:    cod_d = (acnt_d < 7'd4);
            default: cod_d = 1'b0;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign cod_o = cod_q;
    assign busy  = busy_q;

endmodule

// File: doc/codificador_pt2262.md
CODIFICADOR_PT2262 -- requirements
Module: codificador_pt2262

Interface
REQ-001 SHALL provide parameter ALPHA_CYC, default 250, clk cycles per oscillator period α (legal range 2..65535).
REQ-002 SHALL provide parameter MIN_WORDS, default 4, minimum complete code words sent per transmission (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port A_01  input  8  address trit values; bit i is 0 or 1 for trit i when not floating.
REQ-006 SHALL have port A_F  input  8  address float flags; bit i = 1 marks trit i as F.
REQ-007 SHALL have port D  input  4  data bits, binary only.
REQ-008 SHALL have port te  input  1  transmit enable, active-high, level-sensitive.
REQ-009 SHALL have port cod_o  output  1  serial PT2262-format code output.
REQ-010 SHALL have port busy  output  1  high while a transmission is in progress.

Function
REQ-011 SHALL derive a one-cycle α tick from a prescaler counting 0..ALPHA_CYC-1; the prescaler SHALL be held at 0 in IDLE.
REQ-012 Symbol length SHALL be 32α, built from two 16α halves; short half = 4α high then 12α low, long half = 12α high then 4α low.
REQ-013 Trit 0 SHALL be short,short; trit 1 long,long; trit F short,long.
REQ-014 Sync SHALL be 4α high then 124α low (128α).
REQ-015 Word SHALL be 12 symbols then sync (512α total); order: address trit 7 down to 0, then D[3] down to D[0] (D bits sent as trit 0/1).
REQ-016 A_F[i]=1 SHALL force trit F regardless of A_01[i].
REQ-017 A_01, A_F and D SHALL be captured into a 12-trit shift register at each word start; input changes mid-word SHALL NOT affect the word in flight.
REQ-018 FSM states SHALL be IDLE, BIT, SYNC.
REQ-019 IDLE: cod_o=0, busy=0; te sampled high SHALL capture inputs, clear word counter, enter BIT; cod_o SHALL go high and busy high on the next rising edge (1-cycle latency).
REQ-020 BIT: after 32α SHALL advance bit index; after index 11 completes SHALL enter SYNC.
REQ-021 SYNC end: word counter SHALL increment (saturating at 15); if te=1 or counter < MIN_WORDS SHALL recapture inputs and enter BIT with no gap cycle, else enter IDLE.
REQ-022 te deassertion mid-word SHALL NOT truncate the word; the current word and any remaining up to MIN_WORDS SHALL complete.
REQ-023 te reasserted in the same cycle as return to IDLE SHALL start a new transmission on the following edge (single idle cycle).
REQ-024 Every high/low segment SHALL be exactly its α count × ALPHA_CYC clk cycles, no cumulative drift across words.
REQ-025 cod_o and busy SHALL be registered outputs, glitch-free.

Reset
REQ-026 reset low SHALL immediately force state IDLE, cod_o=0, busy=0, all counters and shift register to 0, also mid-word.
REQ-027 After reset release, block SHALL wait in IDLE for te; a te held high through reset SHALL start transmission on the first edge after release.

Verification
REQ-028 ALPHA_CYC=2, MIN_WORDS=4, A_01=8'h00, A_F=8'h00, D=4'h0, te pulse 1 cycle -> exactly 4 words, each 1024 cycles, cod_o pattern per symbol 8H/24L/8H/24L, sync 8H/248L, busy high 4096 cycles then low.
REQ-029 ALPHA_CYC=2, A_01=8'hA5, A_F=8'h0F, D=4'b1001 -> trits 7..0 = 1,0,1,0,F,F,F,F then 1,0,0,1; F symbol 8H/24L/24H/8L; reference PT2272-compatible decode yields same address/data.
REQ-030 te held high for 6 words -> 6 back-to-back words, no gap, busy low exactly after 6th sync ends.
REQ-031 Change A_01 and D during word 2 -> word 2 unchanged, word 3 carries new values.
REQ-032 reset low at bit 5 of word 1 -> cod_o=0, busy=0 within same cycle (asynchronous); te high after release restarts at trit 7 of a fresh word.
REQ-033 A_01[3]=1 with A_F[3]=1 -> trit 3 transmitted as F.
